// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_responder_pkg                                               |
// | Brief   : Mask/FSM encodings, registered request type and lane helpers.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package dmem_responder_pkg;

    localparam logic [3:0] c_MASK_BYTE   = 4'b0001;
    localparam logic [3:0] c_MASK_HALF   = 4'b0011;
    localparam logic [3:0] c_MASK_WORD   = 4'b1111;

    localparam logic [1:0] c_DMEM_IDLE   = 2'd0;
    localparam logic [1:0] c_DMEM_WAIT   = 2'd1;
    localparam logic [1:0] c_DMEM_ACCESS = 2'd2;

    typedef struct packed {
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        read_wr;
        logic        write_wr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] regc_data;
        logic [4:0]  regc_addr;
        logic        regc_wr;
    } ex_req_t;

    function automatic logic [31:0] byte_expand(input logic [3:0] lanes);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = {8{lanes[i]}};
        end
        return res;
    endfunction

    // Bytes are always aligned; halves need an even offset, words offset zero.
    function automatic logic dmem_misaligned(input logic [3:0] size, input logic [1:0] off);
        case (size)
            c_MASK_BYTE: return 1'b0;
            c_MASK_HALF: return off[0];
            c_MASK_WORD: return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_responder_if                                                |
// | Brief   : Execute-stage memory request bus and MEM-stage write-back bus.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface dmem_responder_if;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic        readWr;
    logic        writeWr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] regcData_i;
    logic [4:0]  regcAddr_i;
    logic        regcWr_i;
    logic        stall;
    logic [31:0] regcData;
    logic [4:0]  regcAddr;
    logic        regcWr;
    logic        misalign;
    logic        mem_regWr;
    logic [31:0] mem_data;
    logic [4:0]  mem_regAddr;

    modport master (
        output memAddr, memData, readWr, writeWr, rmask, wmask,
               regcData_i, regcAddr_i, regcWr_i,
        input  stall, regcData, regcAddr, regcWr, misalign,
               mem_regWr, mem_data, mem_regAddr
    );

    modport slave (
        input  memAddr, memData, readWr, writeWr, rmask, wmask,
               regcData_i, regcAddr_i, regcWr_i,
        output stall, regcData, regcAddr, regcWr, misalign,
               mem_regWr, mem_data, mem_regAddr
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_ram                                                         |
// | Brief   : DEPTH x 32 data RAM, byte write enables, sync write/comb read.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_ram #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic [3:0]    i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_responder                                                   |
// | Brief   : MEM-stage responder: byte-masked loads/stores with wait states.  |
// |           Optional alignment check enabled by DMEM_ALIGN_CHK_EN.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input wire logic     clk,
    input wire logic     rst,
    dmem_responder_if.slave bus
);

    localparam int         c_AW   = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    ex_req_t     w_req_in, r_req;
    logic [1:0]  r_state, w_next_state;
    logic [3:0]  r_cnt, w_next_cnt;
    logic        w_stall, w_complete, w_mem_op, w_is_store, w_is_load, w_misalign;
    logic [1:0]  w_off;
    logic [3:0]  w_size, w_lanes, w_we;
    logic [31:0] w_rdata, w_wdata, w_load_data;
    logic [31:0] r_regc_data;
    logic [4:0]  r_regc_addr;
    logic        r_regc_wr, r_misalign;
    logic        w_unused_addr;

    assign w_req_in = '{
        mem_addr:  bus.memAddr,    mem_data:  bus.memData,
        read_wr:   bus.readWr,     write_wr:  bus.writeWr,
        rmask:     bus.rmask,      wmask:     bus.wmask,
        regc_data: bus.regcData_i, regc_addr: bus.regcAddr_i,
        regc_wr:   bus.regcWr_i
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= '0;
        end else if (!w_stall) begin
            r_req <= w_req_in;
        end
    end

    // A store wins when both request bits are set.
    assign w_mem_op   = r_req.read_wr | r_req.write_wr;
    assign w_is_store = r_req.write_wr;
    assign w_is_load  = r_req.read_wr & ~r_req.write_wr;
    assign w_size     = w_is_store ? r_req.wmask : r_req.rmask;
    assign w_off      = r_req.mem_addr[1:0];
    assign w_lanes    = w_size << w_off;
    assign w_wdata    = r_req.mem_data << {w_off, 3'b000};
    assign w_load_data = (w_rdata & byte_expand(w_lanes)) >> {w_off, 3'b000};
    assign w_unused_addr = ^r_req.mem_addr[31:c_AW+2];

`ifdef DMEM_ALIGN_CHK_EN
    assign w_misalign = w_mem_op & dmem_misaligned(w_size, w_off);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_DMEM_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_DMEM_IDLE: begin
                if (w_mem_op && c_WAIT != 4'd0) begin
                    if (c_WAIT == 4'd1) begin
                        w_next_state = c_DMEM_ACCESS;
                    end else begin
                        w_next_state = c_DMEM_WAIT;
                        w_next_cnt   = c_WAIT - 4'd1;
                    end
                end
            end
            c_DMEM_WAIT: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next_state = c_DMEM_ACCESS;
                end
            end
            c_DMEM_ACCESS: w_next_state = c_DMEM_IDLE;
            default:       w_next_state = c_DMEM_IDLE;
        endcase
    end

    always_comb begin
        w_stall    = ((r_state == c_DMEM_IDLE) && w_mem_op && (c_WAIT != 4'd0))
                   || (r_state == c_DMEM_WAIT);
        w_complete = ((r_state == c_DMEM_IDLE) && !(w_mem_op && (c_WAIT != 4'd0)))
                   || (r_state == c_DMEM_ACCESS);
    end

    // Reset on the access edge must not commit the store.
    assign w_we = (w_complete && w_is_store && !w_misalign && !rst) ? w_lanes : 4'b0000;

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_req.mem_addr[c_AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regc_data <= '0;
            r_regc_addr <= '0;
            r_regc_wr   <= 1'b0;
            r_misalign  <= 1'b0;
        end else if (w_complete) begin
            r_regc_data <= w_is_load ? w_load_data : r_req.regc_data;
            r_regc_addr <= r_req.regc_addr;
            r_regc_wr   <= r_req.regc_wr & ~w_misalign;
            r_misalign  <= w_misalign;
        end else begin
            r_regc_wr   <= 1'b0;
            r_misalign  <= 1'b0;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.regcData    = r_regc_data;
    assign bus.regcAddr    = r_regc_addr;
    assign bus.regcWr      = r_regc_wr;
    assign bus.misalign    = r_misalign;
    assign bus.mem_regWr   = r_regc_wr;
    assign bus.mem_data    = r_regc_data;
    assign bus.mem_regAddr = r_regc_addr;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_responder                                                |
// | Brief   : Directed bench for dmem_responder at 0, 2 and 3 wait states.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic    clk = 1'b0;
    logic    rst0, rst2, rst3;
    ex_req_t q0, q2, q3;
    int      n_checks = 0;
    int      n_fail   = 0;

    dmem_responder_if if0 ();
    dmem_responder_if if2 ();
    dmem_responder_if if3 ();

    assign if0.memAddr = q0.mem_addr;   assign if0.memData = q0.mem_data;
    assign if0.readWr  = q0.read_wr;    assign if0.writeWr = q0.write_wr;
    assign if0.rmask   = q0.rmask;      assign if0.wmask   = q0.wmask;
    assign if0.regcData_i = q0.regc_data; assign if0.regcAddr_i = q0.regc_addr;
    assign if0.regcWr_i   = q0.regc_wr;

    assign if2.memAddr = q2.mem_addr;   assign if2.memData = q2.mem_data;
    assign if2.readWr  = q2.read_wr;    assign if2.writeWr = q2.write_wr;
    assign if2.rmask   = q2.rmask;      assign if2.wmask   = q2.wmask;
    assign if2.regcData_i = q2.regc_data; assign if2.regcAddr_i = q2.regc_addr;
    assign if2.regcWr_i   = q2.regc_wr;

    assign if3.memAddr = q3.mem_addr;   assign if3.memData = q3.mem_data;
    assign if3.readWr  = q3.read_wr;    assign if3.writeWr = q3.write_wr;
    assign if3.rmask   = q3.rmask;      assign if3.wmask   = q3.wmask;
    assign if3.regcData_i = q3.regc_data; assign if3.regcAddr_i = q3.regc_addr;
    assign if3.regcWr_i   = q3.regc_wr;

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));
    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(if3.slave));

    always #5 clk = ~clk;

    function automatic ex_req_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] rm,
                                   input logic [3:0] wm, input logic [31:0] rcd,
                                   input logic [4:0] rca, input logic rcw);
        ex_req_t r;
        r = '{mem_addr: addr, mem_data: data, read_wr: rd, write_wr: wr, rmask: rm,
              wmask: wm, regc_data: rcd, regc_addr: rca, regc_wr: rcw};
        return r;
    endfunction

    function automatic ex_req_t st(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [3:0] m);
        return mk(1'b0, 1'b1, addr, data, 4'b0000, m, 32'h5757_5757, 5'd0, 1'b0);
    endfunction

    function automatic ex_req_t ld(input logic [31:0] addr, input logic [3:0] m,
                                   input logic [4:0] rd);
        return mk(1'b1, 1'b0, addr, 32'h0, m, 4'b0000, 32'hEEEE_EEEE, rd, 1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        q0 = '0; q2 = '0; q3 = '0;
        tick(); tick();
        chk("rst_regcWr0",   32'(if0.regcWr),    32'h0);
        chk("rst_regcData0", if0.regcData,        32'h0);
        chk("rst_misalign0", 32'(if0.misalign),  32'h0);
        chk("rst_stall3",    32'(if3.stall),     32'h0);
        chk("rst_memregwr2", 32'(if2.mem_regWr), 32'h0);
        rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;

        // ---- W=0: word store then word load ----
        q0 = st(32'h10, 32'hDEAD_BEEF, 4'hF); tick();
        chk("w0_stall_a", 32'(if0.stall), 32'h0);
        q0 = ld(32'h10, 4'hF, 5'd5); tick();
        chk("w0_stall_b", 32'(if0.stall), 32'h0);
        chk("w0_st_regcWr", 32'(if0.regcWr), 32'h0);
        q0 = '0; tick();
        chk("w0_ld_data",   if0.regcData,        32'hDEAD_BEEF);
        chk("w0_ld_wr",     32'(if0.regcWr),     32'h1);
        chk("w0_ld_addr",   32'(if0.regcAddr),   32'd5);
        chk("w0_fwd_data",  if0.mem_data,        32'hDEAD_BEEF);
        chk("w0_fwd_wr",    32'(if0.mem_regWr),  32'h1);
        chk("w0_fwd_addr",  32'(if0.mem_regAddr), 32'd5);

        // ---- W=0: byte merge and sub-word loads, back to back ----
        q0 = st(32'h10, 32'h1122_3344, 4'hF); tick();
        q0 = st(32'h13, 32'h0000_00AB, 4'h1); tick();
        q0 = ld(32'h10, 4'hF, 5'd6); tick();
        q0 = ld(32'h13, 4'h1, 5'd7); tick();
        chk("byte_merge_word", if0.regcData, 32'hAB22_3344);
        q0 = ld(32'h12, 4'h3, 5'd8); tick();
        chk("ld_byte_13", if0.regcData, 32'h0000_00AB);
        chk("ld_byte_13_addr", 32'(if0.regcAddr), 32'd7);
        q0 = ld(32'h13, 4'h3, 5'd9); tick();
        chk("ld_half_12", if0.regcData, 32'h0000_AB22);
        q0 = ld(32'h10, 4'h0, 5'd10); tick();
        chk("ld_half_13_drop", if0.regcData, 32'h0000_00AB);
        q0 = '0; tick();
        chk("ld_mask0_data", if0.regcData, 32'h0);
        chk("ld_mask0_wr", 32'(if0.regcWr), 32'h1);

        // ---- W=0: load and store both asserted ----
        q0 = mk(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, 4'hF, 32'h77, 5'd9, 1'b1); tick();
        q0 = ld(32'h20, 4'hF, 5'd10); tick();
        chk("both_data", if0.regcData, 32'h77);
        chk("both_wr", 32'(if0.regcWr), 32'h1);
        chk("both_addr", 32'(if0.regcAddr), 32'd9);
        q0 = '0; tick();
        chk("both_mem", if0.regcData, 32'h5);

        // ---- W=0: word store at offset 2 ----
        q0 = st(32'h40, 32'h5566_7788, 4'hF); tick();
        q0 = mk(1'b0, 1'b1, 32'h42, 32'hAAAA_BBBB, 4'h0, 4'hF, 32'h33, 5'd3, 1'b1); tick();
        q0 = ld(32'h40, 4'hF, 5'd11); tick();
`ifdef DMEM_ALIGN_CHK_EN
        chk("mis_st_flag", 32'(if0.misalign), 32'h1);
        chk("mis_st_wr", 32'(if0.regcWr), 32'h0);
`else
        chk("mis_st_flag", 32'(if0.misalign), 32'h0);
        chk("mis_st_wr", 32'(if0.regcWr), 32'h1);
`endif
        q0 = ld(32'h42, 4'h3, 5'd12); tick();
        chk("mis_flag_clear", 32'(if0.misalign), 32'h0);
`ifdef DMEM_ALIGN_CHK_EN
        chk("mis_st_ram", if0.regcData, 32'h5566_7788);
`else
        chk("mis_st_ram", if0.regcData, 32'hBBBB_7788);
`endif
        q0 = '0; tick();
        chk("half_42_flag", 32'(if0.misalign), 32'h0);
`ifdef DMEM_ALIGN_CHK_EN
        chk("half_42_data", if0.regcData, 32'h0000_5566);
`else
        chk("half_42_data", if0.regcData, 32'h0000_BBBB);
`endif

        // ---- W=3: stall window and held ALU op ----
        q3 = st(32'h30, 32'hCAFE_F00D, 4'hF); tick();
        chk("w3_st_stall_c1", 32'(if3.stall), 32'h1);
        q3 = '0; tick(); tick(); tick();
        chk("w3_st_stall_c4", 32'(if3.stall), 32'h0);
        tick();
        q3 = ld(32'h30, 4'hF, 5'd13); tick();
        chk("w3_c1_stall", 32'(if3.stall), 32'h1);
        chk("w3_c1_wr", 32'(if3.regcWr), 32'h0);
        q3 = mk(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h1234, 5'd14, 1'b1); tick();
        chk("w3_c2_stall", 32'(if3.stall), 32'h1);
        chk("w3_c2_wr", 32'(if3.regcWr), 32'h0);
        tick();
        chk("w3_c3_stall", 32'(if3.stall), 32'h1);
        chk("w3_c3_wr", 32'(if3.regcWr), 32'h0);
        tick();
        chk("w3_c4_stall", 32'(if3.stall), 32'h0);
        chk("w3_c4_wr", 32'(if3.regcWr), 32'h0);
        tick();
        chk("w3_c5_data", if3.regcData, 32'hCAFE_F00D);
        chk("w3_c5_wr", 32'(if3.regcWr), 32'h1);
        chk("w3_c5_addr", 32'(if3.regcAddr), 32'd13);
        chk("w3_c5_stall", 32'(if3.stall), 32'h0);
        q3 = '0; tick();
        chk("w3_alu_data", if3.regcData, 32'h1234);
        chk("w3_alu_addr", 32'(if3.regcAddr), 32'd14);
        chk("w3_alu_wr", 32'(if3.regcWr), 32'h1);

        // ---- W=2: reset in the middle of a store ----
        q2 = st(32'h40, 32'h0BAD_F00D, 4'hF); tick();
        q2 = '0; tick(); tick(); tick();
        q2 = mk(1'b0, 1'b1, 32'h40, 32'h9999_9999, 4'h0, 4'hF, 32'h44, 5'd4, 1'b1); tick();
        chk("w2_c1_stall", 32'(if2.stall), 32'h1);
        tick();
        chk("w2_c2_stall", 32'(if2.stall), 32'h1);
        rst2 = 1'b1; q2 = '0; tick();
        chk("w2_rst_wr", 32'(if2.regcWr), 32'h0);
        chk("w2_rst_data", if2.regcData, 32'h0);
        chk("w2_rst_addr", 32'(if2.regcAddr), 32'h0);
        chk("w2_rst_fwd", 32'(if2.mem_regWr), 32'h0);
        chk("w2_rst_stall", 32'(if2.stall), 32'h0);
        rst2 = 1'b0; tick();
        chk("w2_idle_stall", 32'(if2.stall), 32'h0);
        q2 = ld(32'h40, 4'hF, 5'd15); tick();
        chk("w2_ld_stall", 32'(if2.stall), 32'h1);
        q2 = '0; tick(); tick(); tick();
        chk("w2_ram_kept", if2.regcData, 32'h0BAD_F00D);
        chk("w2_ld_wr", 32'(if2.regcWr), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
